// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the dual-write register file.
package reg_file_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int REG_ZERO    = 0;
  localparam int REG_OUT_DEF = 15;

  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for outstanding loads; set on issue, cleared on load return.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ISSUE_EN,
  input  logic [ADDR_W-1:0] ISSUE_A,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic              BUSY1,
  output logic              BUSY2
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_p0;
  logic [DEPTH-1:0] busy_nxt;

  // Clear first, then set, so a back-to-back load on the same register keeps it busy.
  always_comb begin
    busy_nxt = busy_p0;
    if (WE1) busy_nxt[WA1] = 1'b0;
    if (ISSUE_EN) busy_nxt[ISSUE_A] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) busy_p0 <= '0;
    else     busy_p0 <= busy_nxt;
  end

  assign BUSY1 = busy_p0[RA1];
  assign BUSY2 = busy_p0[RA2];
endmodule

// File: rtl/reg_file_2w.sv
// Two-read, two-write register file with write-through bypass, load scoreboard
// and a mirrored output register with a one-cycle update strobe.
module reg_file_2w
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OUT_REG = REG_OUT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WA0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              ISSUE_EN,
  input  logic [ADDR_W-1:0] ISSUE_A,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              STALL,
  output logic [DATA_W-1:0] cpu_out,
  output logic              out_valid
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] OUT_A  = ADDR_W'(OUT_REG);

  logic [DATA_W-1:0] store_p0 [DEPTH];
  logic              out_vld_p0;

  // Port 1 is applied after port 0 so the load return wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) store_p0[i] <= '0;
      out_vld_p0 <= 1'b0;
    end else begin
      if (WE0 && WA0 != ZERO_A) store_p0[WA0] <= WD0;
      if (WE1 && WA1 != ZERO_A) store_p0[WA1] <= WD1;
      out_vld_p0 <= (WE0 && WA0 == OUT_A) || (WE1 && WA1 == OUT_A);
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra,
                                                  input logic [DATA_W-1:0] stored);
    if (ra == ZERO_A)            return '0;
    else if (WE1 && WA1 == ra)   return WD1;
    else if (WE0 && WA0 == ra)   return WD0;
    else                         return stored;
  endfunction

  assign RD1       = read_port(RA1, store_p0[RA1]);
  assign RD2       = read_port(RA2, store_p0[RA2]);
  assign cpu_out   = store_p0[OUT_A];
  assign out_valid = out_vld_p0;
  assign STALL     = BUSY1 | BUSY2;

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .CLK      (CLK),
    .RST      (RST),
    .ISSUE_EN (ISSUE_EN),
    .ISSUE_A  (ISSUE_A),
    .WE1      (WE1),
    .WA1      (WA1),
    .RA1      (RA1),
    .RA2      (RA2),
    .BUSY1    (BUSY1),
    .BUSY2    (BUSY2)
  );
endmodule

// File: tb/tb_reg_file_2w.sv
// Directed bench for reg_file_2w: reset, bypass, port priority, r0, output strobe, scoreboard.
module tb_reg_file_2w;
  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] RA1, RA2, WA0, WA1, ISSUE_A;
  logic [7:0] RD1, RD2, WD0, WD1, cpu_out;
  logic       WE0, WE1, ISSUE_EN, BUSY1, BUSY2, STALL, out_valid;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  reg_file_2w #(.DATA_W(8), .ADDR_W(4), .OUT_REG(15)) dut (
    .CLK(CLK), .RST(RST), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
    .ISSUE_EN(ISSUE_EN), .ISSUE_A(ISSUE_A), .BUSY1(BUSY1), .BUSY2(BUSY2),
    .STALL(STALL), .cpu_out(cpu_out), .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge; inputs then change 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; RA1 = 0; RA2 = 0; WE0 = 0; WA0 = 0; WD0 = 0;
    WE1 = 0; WA1 = 0; WD1 = 0; ISSUE_EN = 0; ISSUE_A = 0;
    tick();
    RST = 1'b0;

    // Reset state across all addresses
    for (int a = 0; a < 16; a++) begin
      RA1 = 4'(a); RA2 = 4'(15 - a);
      #1;
      check("rst_rd1", RD1, 8'h00);
      check("rst_rd2", RD2, 8'h00);
      check("rst_stall", {7'b0, STALL}, 8'h00);
    end
    check("rst_cpu_out", cpu_out, 8'h00);
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);

    // Write-through bypass on port 0
    WE0 = 1; WA0 = 3; WD0 = 8'hA5; RA1 = 3;
    #1 check("byp0_same", RD1, 8'hA5);
    tick();
    WE0 = 0;
    #1 check("byp0_stored", RD1, 8'hA5);

    // Same-address dual write: port 1 wins in bypass and in storage
    WE0 = 1; WA0 = 5; WD0 = 8'h11; WE1 = 1; WA1 = 5; WD1 = 8'h22; RA2 = 5;
    #1 check("dual_same_byp", RD2, 8'h22);
    tick();
    WE0 = 0; WE1 = 0;
    #1 check("dual_same_store", RD2, 8'h22);

    // Different-address dual write: both commit
    WE0 = 1; WA0 = 2; WD0 = 8'h12; WE1 = 1; WA1 = 4; WD1 = 8'h34;
    tick();
    WE0 = 0; WE1 = 0; RA1 = 2; RA2 = 4;
    #1 check("dual_diff_p0", RD1, 8'h12);
    check("dual_diff_p1", RD2, 8'h34);

    // r0 ignores writes and reads zero
    WE0 = 1; WA0 = 0; WD0 = 8'hFF; RA1 = 0;
    #1 check("r0_same", RD1, 8'h00);
    tick();
    WE0 = 0;
    #1 check("r0_after", RD1, 8'h00);
    check("ov_idle", {7'b0, out_valid}, 8'h00);

    // Output register: cpu_out has no bypass, strobe lasts one cycle
    WE1 = 1; WA1 = 15; WD1 = 8'h7E;
    #1 check("cpu_out_nobyp", cpu_out, 8'h00);
    check("ov_before", {7'b0, out_valid}, 8'h00);
    tick();
    WE1 = 0;
    #1 check("cpu_out_upd", cpu_out, 8'h7E);
    check("ov_pulse", {7'b0, out_valid}, 8'h01);
    tick();
    RA1 = 15;
    #1 check("ov_drop", {7'b0, out_valid}, 8'h00);
    check("cpu_out_hold", cpu_out, 8'h7E);
    check("rd_out_reg", RD1, 8'h7E);

    // Continuous writes to OUT_REG keep the strobe high
    WE0 = 1; WA0 = 15; WD0 = 8'h01;
    tick();
    WD0 = 8'h02;
    #1 check("ov_stream1", {7'b0, out_valid}, 8'h01);
    tick();
    WE0 = 0;
    #1 check("ov_stream2", {7'b0, out_valid}, 8'h01);
    check("cpu_out_stream", cpu_out, 8'h02);

    // ISSUE_A == 0 is ignored
    ISSUE_EN = 1; ISSUE_A = 0;
    tick();
    ISSUE_EN = 0; RA1 = 0; RA2 = 0;
    #1 check("issue_r0", {7'b0, STALL}, 8'h00);

    // Scoreboard set: visible only from the registered bit
    ISSUE_EN = 1; ISSUE_A = 6; RA1 = 6; RA2 = 0;
    #1 check("busy_no_byp", {7'b0, BUSY1}, 8'h00);
    tick();
    ISSUE_EN = 0;
    #1 check("busy1_set", {7'b0, BUSY1}, 8'h01);
    check("stall_set", {7'b0, STALL}, 8'h01);
    RA1 = 0; RA2 = 6;
    #1 check("busy2_set", {7'b0, BUSY2}, 8'h01);
    check("busy1_r0", {7'b0, BUSY1}, 8'h00);

    // Port-0 write leaves busy bit alone
    WE0 = 1; WA0 = 6; WD0 = 8'h5A;
    tick();
    WE0 = 0;
    #1 check("p0_no_clear", {7'b0, BUSY2}, 8'h01);

    // Set and clear together: set wins
    RA1 = 6;
    ISSUE_EN = 1; ISSUE_A = 6; WE1 = 1; WA1 = 6; WD1 = 8'h33;
    tick();
    ISSUE_EN = 0; WE1 = 0;
    #1 check("set_wins", {7'b0, BUSY1}, 8'h01);
    check("load_data", RD1, 8'h33);

    // Clear on load return
    WE1 = 1; WA1 = 6; WD1 = 8'h44;
    #1 check("clear_no_byp", {7'b0, BUSY1}, 8'h01);
    tick();
    WE1 = 0;
    #1 check("busy_clear", {7'b0, BUSY1}, 8'h00);
    check("stall_clear", {7'b0, STALL}, 8'h00);
    check("load_data2", RD1, 8'h44);

    // Reset mid-load, with a write in the same cycle that reset must override
    ISSUE_EN = 1; ISSUE_A = 6;
    tick();
    ISSUE_EN = 0;
    #1 check("busy_reissue", {7'b0, STALL}, 8'h01);
    RST = 1; WE0 = 1; WA0 = 3; WD0 = 8'h99;
    tick();
    RST = 0; WE0 = 0;
    #1 check("stall_after_rst", {7'b0, STALL}, 8'h00);
    check("rd_after_rst", RD1, 8'h00);
    check("cpu_out_after_rst", cpu_out, 8'h00);
    RA2 = 3;
    #1 check("rst_over_write", RD2, 8'h00);
    WE1 = 1; WA1 = 6; WD1 = 8'h55;
    tick();
    WE1 = 0;
    #1 check("load_after_rst", RD1, 8'h55);
    check("busy_after_load", {7'b0, BUSY1}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
